// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants for the up/down modulo counter family
package cnt_pkg;
  localparam int CNT_D_BIT = 8;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam logic CNT_UP   = 1'b1;
endpackage

// File: rtl/cnt_next_calc.sv
// cnt_next_calc: next count value and terminal detection for one count event
module cnt_next_calc
  import cnt_pkg::*;
#(
  parameter int D_BIT = CNT_D_BIT
) (
  input  logic [D_BIT-1:0] q,
  input  logic [D_BIT-1:0] limit,
  input  logic             up,
  input  logic             sat,
  output logic [D_BIT-1:0] q_next,
  output logic             term
);
  // >= so a limit lowered below q terminates instead of running through all-ones
  always_comb begin
    term   = (up == CNT_UP) ? (q >= limit) : (q == '0);
    q_next = (up == CNT_UP)
           ? (term ? ((sat == CNT_SAT) ? q : '0) : q + 1'b1)
           : (term ? ((sat == CNT_SAT) ? q : limit) : q - 1'b1);
  end
endmodule

// File: rtl/cnt_reg_updn.sv
// cnt_reg_updn: loadable up/down modulo counter with wrap/saturate,
// registered terminal-count pulse and sticky overflow flag
module cnt_reg_updn
  import cnt_pkg::*;
#(
  parameter int               D_BIT   = CNT_D_BIT,
  parameter logic [D_BIT-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             en_count,
  input  logic             up,
  input  logic             sat,
  input  logic [D_BIT-1:0] d,
  input  logic [D_BIT-1:0] limit,
  output logic [D_BIT-1:0] q,
  output logic             tc,
  output logic             ovf
);
  logic [D_BIT-1:0] q_q, q_d, q_next;
  logic             tc_q, tc_d, ovf_q, ovf_d, term;
  cnt_next_calc #(.D_BIT(D_BIT)) u_next (
    .q(q_q), .limit(limit), .up(up), .sat(sat), .q_next(q_next), .term(term)
  );
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      q_d   = RST_VAL;
      ovf_d = 1'b0;
    end else if (en && load) begin
      q_d   = d;
      ovf_d = 1'b0;
    end else if (en && en_count) begin
      q_d   = q_next;
      tc_d  = term;
      ovf_d = ovf_q | term;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= RST_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
endmodule

// File: doc/cnt_reg_updn.md
Name: cnt_reg_updn

Overview:
- Parametrised successor of the team's loadable counter register.
- Adds up/down direction, a programmable modulo limit, and a wrap-or-saturate mode.
- Adds a registered terminal-count pulse and a sticky overflow flag.
- Intended as the general counting primitive for the UART: baud divider, bit counter and timeout counters.

Parameters:
- D_BIT, 8, counter/data width in bits (≥2).
- RST_VAL, 0, value of q after reset and after clr.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- en  in  1  global enable; when 0 all state holds (except clr).
- clr  in  1  synchronous clear; highest priority after rst.
- load  in  1  synchronous parallel load of d (qualified by en).
- en_count  in  1  count enable (qualified by en).
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 0 = wrap (modulo limit+1), 1 = saturate.
- d  in  D_BIT  load data.
- limit  in  D_BIT  terminal value for up count; wrap target for down count.
- q  out  D_BIT  counter value (registered).
- tc  out  1  terminal-count pulse (registered, one cycle per event).
- ovf  out  1  sticky overflow/underflow flag (registered).

Behaviour:
- Reset (rst=0, async): q=RST_VAL, tc=0, ovf=0. Release is synchronous to the next clk edge; first action follows on the first edge with rst=1.
- Per-edge priority: clr > (en & load) > (en & en_count) > hold.
- clr=1: q=RST_VAL, ovf=0, tc=0, regardless of en.
- en=1, load=1: q=d; ovf=0; tc=0; en_count is ignored that cycle.
- d > limit is loaded as-is, with no clamping.
- Count event (en=1, load=0, en_count=1):
  - up=1, q<limit: q=q+1.
  - up=1, q>=limit (terminal):
    - sat=0: q=0.
    - sat=1: q holds.
  - up=0, q>0: q=q-1.
  - up=0, q==0 (terminal):
    - sat=0: q=limit.
    - sat=1: q holds at 0.
- Terminal count event:
  - tc=1 in the cycle after the edge that evaluated the terminal condition; otherwise tc=0.
  - tc is never held high by a stalled count. In saturate mode, each further count event at the terminal value produces another one-cycle tc.
  - ovf is set at the same edge (sticky); cleared only by rst, clr or load.
- No count event (en=0 or en_count=0): q and ovf hold, tc=0.
- limit=0: up count keeps q=0 with tc on every event; down count from 0 keeps q=0 with tc on every event.
- limit changed while q>limit, up count: the next count is terminal (q wraps to 0 or holds). No passage through 2^D_BIT-1 is permitted.
- Arithmetic is unsigned, D_BIT wide; no carry bit is exported.
- Latency: q and tc update one edge after the qualifying inputs are sampled.

Decomposition:
- Shared package cnt_pkg:
  - mode constants CNT_WRAP=1'b0, CNT_SAT=1'b1.
  - direction constants CNT_DN=1'b0, CNT_UP=1'b1.
  - default D_BIT.
- One combinational sub-module, cnt_next_calc:
  - inputs: q, limit, up, sat.
  - outputs: q_next, term.
- Top module holds the registers and the priority logic.

Test Plan (D_BIT=8):
1. rst=0 asserted asynchronously mid-count at q=0x23, between clk edges -> q=0x00, tc=0, ovf=0 immediately; after rst=1, q stays 0 until the first count.
2. Load d=0x05, limit=0x07, up=1, sat=0, en_count for 4 cycles -> q=0x06,0x07,0x00,0x01; tc high exactly one cycle, after the 0x07->0x00 edge; ovf=1 and stays 1.
3. Load d=0x06, limit=0x07, up=1, sat=1, count 3 cycles -> q=0x07,0x07,0x07; tc pulses on 2nd and 3rd events (two separate one-cycle pulses); ovf=1.
4. Load d=0x01, limit=0x03, up=0, sat=0, count 3 cycles -> q=0x00,0x03,0x02; single tc after 0x00->0x03; load d=0x10 -> ovf=0.
5. load=1 and en_count=1 in the same cycle with d=0x0A -> q=0x0A, no increment. en=0 with en_count=1 for 3 cycles -> q holds 0x0A, tc=0.
6. clr=1 and load=1 in the same cycle with en=0 -> q=0x00, ovf=0. Then limit=0x00, up=1, count 2 cycles -> q=0x00, tc pulse after each event.
